inst_fetch: RTL and testbench

Instruction fetch stage of the out-of-order RISC-V core. Sits directly upstream of the memory controller's instruction port and directly upstream of decode/issue. Holds the PC and looks it up in a direct-mapped instruction cache. On a miss it requests the word from the memory controller and fills the cache. It presents one instruction per cycle with a statically predicted next PC, and redirects on branch misprediction.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch_icache.sv | 61 ++++++
 rtl/inst_fetch.sv | 170 +++++++++++++++++
 tb/tb_inst_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - TRUE / FALSE single-bit constants
//   - OPC_JAL opcode used by the static next-PC predictor
//   - fetch_state_e FSM encodings (LOOKUP, WAIT_MEM)
//   - predict_next(): static next-PC prediction for one fetched word
package inst_fetch_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic {
    LOOKUP   = 1'b0,
    WAIT_MEM = 1'b1
  } fetch_state_e;

  // JAL targets are followed (J-immediate, wraps modulo 2^32); everything
  // else, including conditional branches, falls through to pc + 4.
  function automatic logic [31:0] predict_next(input logic [31:0] pc,
                                               input logic [31:0] word);
    logic [31:0] imm;
    imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    if (word[6:0] == OPC_JAL) begin
      return pc + imm;
    end
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Lookup is combinational so the fetch stage can decide hit/miss in the same
// cycle the PC is presented. Valid bits clear synchronously on rst; tag and
// data contents are left as-is (they are meaningless while invalid).
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears valid bits)
//   rd_idx, rd_tag    lookup address split into line index and tag
//   hit, rd_data      combinational lookup result
//   wr_en             fill strobe
//   wr_idx, wr_tag    line being filled and its tag
//   wr_data           fill word
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int LINES = 256,
  parameter int IDX   = 8,
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX-1:0]   rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_reg;
  logic [LINES-1:0] line_wr;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // One-hot fill select, one bit per line.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_sel
      assign line_wr[gi] = wr_en && (wr_idx == IDX'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= {LINES{FALSE}};
    end else begin
      valid_reg <= valid_reg | line_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, looks it up in a direct-mapped
// instruction cache, fetches misses from the memory controller and presents
// one instruction per cycle with a statically predicted next PC.
// Build option: ICACHE_EN -- when defined the cache is instantiated; when
// undefined every lookup misses and each instruction is fetched from memory.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable, low freezes all state
//   jump_wrong_flag/_pc      misprediction redirect (pc[1:0] forced to 0)
//   mc_req, mc_addr          request to memory controller, held until mc_done
//   mc_done, mc_inst         one-cycle completion pulse and fetched word
//   issue_stall              downstream cannot accept this cycle
//   inst_valid, inst,        output slot: instruction, its PC and the
//   inst_pc, inst_pred_pc    predicted next PC
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          ICACHE_LINES = 256,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_flag,
  input  logic [31:0] jump_wrong_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_inst,
  input  logic        issue_stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc
);

  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX;

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         mc_req_reg, mc_req_next;
  logic [31:0]  mc_addr_reg, mc_addr_next;
  logic         inst_valid_reg, inst_valid_next;
  logic [31:0]  inst_reg, inst_next;
  logic [31:0]  inst_pc_reg, inst_pc_next;
  logic [31:0]  inst_pred_pc_reg, inst_pred_pc_next;

  logic         cache_hit;
  logic [31:0]  cache_word;
  logic         slot_free;
  logic [31:0]  fetch_word;
  logic [31:0]  pred_pc;

`ifdef ICACHE_EN
  logic fill_en;

  // A redirect in the same cycle as mc_done discards the returning word.
  assign fill_en = !rst && rdy && !jump_wrong_flag &&
                   (state_reg == WAIT_MEM) && mc_done;

  // In WAIT_MEM pc_reg equals the outstanding mc_addr, so the same PC
  // fields address both the lookup and the fill.
  inst_fetch_icache #(
    .LINES (ICACHE_LINES),
    .IDX   (IDX),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_reg[IDX+1:2]),
    .rd_tag  (pc_reg[31:IDX+2]),
    .hit     (cache_hit),
    .rd_data (cache_word),
    .wr_en   (fill_en),
    .wr_idx  (pc_reg[IDX+1:2]),
    .wr_tag  (pc_reg[31:IDX+2]),
    .wr_data (mc_inst)
  );
`else
  assign cache_hit  = FALSE;
  assign cache_word = 32'h0;
`endif

  assign slot_free  = !inst_valid_reg || !issue_stall;
  assign fetch_word = (state_reg == WAIT_MEM) ? mc_inst : cache_word;
  assign pred_pc    = predict_next(pc_reg, fetch_word);

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    mc_req_next       = mc_req_reg;
    mc_addr_next      = mc_addr_reg;
    inst_valid_next   = inst_valid_reg;
    inst_next         = inst_reg;
    inst_pc_next      = inst_pc_reg;
    inst_pred_pc_next = inst_pred_pc_reg;

    if (rdy) begin
      if (jump_wrong_flag) begin
        pc_next         = {jump_wrong_pc[31:2], 2'b00};
        inst_valid_next = FALSE;
        mc_req_next     = FALSE;
        state_next      = LOOKUP;
      end else begin
        case (state_reg)
          LOOKUP: begin
            if (slot_free) begin
              if (cache_hit) begin
                inst_valid_next   = TRUE;
                inst_next         = fetch_word;
                inst_pc_next      = pc_reg;
                inst_pred_pc_next = pred_pc;
                pc_next           = pred_pc;
              end else begin
                // Slot is free, so any held instruction leaves this edge.
                mc_req_next     = TRUE;
                mc_addr_next    = pc_reg;
                inst_valid_next = FALSE;
                state_next      = WAIT_MEM;
              end
            end
          end
          WAIT_MEM: begin
            if (mc_done) begin
              inst_valid_next   = TRUE;
              inst_next         = fetch_word;
              inst_pc_next      = pc_reg;
              inst_pred_pc_next = pred_pc;
              pc_next           = pred_pc;
              mc_req_next       = FALSE;
              state_next        = LOOKUP;
            end
          end
          default: state_next = LOOKUP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= LOOKUP;
      pc_reg           <= RESET_PC;
      mc_req_reg       <= FALSE;
      mc_addr_reg      <= 32'h0;
      inst_valid_reg   <= FALSE;
      inst_reg         <= 32'h0;
      inst_pc_reg      <= 32'h0;
      inst_pred_pc_reg <= 32'h0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      mc_req_reg       <= mc_req_next;
      mc_addr_reg      <= mc_addr_next;
      inst_valid_reg   <= inst_valid_next;
      inst_reg         <= inst_next;
      inst_pc_reg      <= inst_pc_next;
      inst_pred_pc_reg <= inst_pred_pc_next;
    end
  end

  assign mc_req       = mc_req_reg;
  assign mc_addr      = mc_addr_reg;
  assign inst_valid   = inst_valid_reg;
  assign inst         = inst_reg;
  assign inst_pc      = inst_pc_reg;
  assign inst_pred_pc = inst_pred_pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. Works with and without ICACHE_EN;
// cache-dependent expectations are selected with the same macro.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        jump_wrong_flag = 1'b0;
  logic [31:0] jump_wrong_pc = 32'h0;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done = 1'b0;
  logic [31:0] mc_inst = 32'h0;
  logic        issue_stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pred_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch #(.ICACHE_LINES(256), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .jump_wrong_flag (jump_wrong_flag),
    .jump_wrong_pc   (jump_wrong_pc),
    .mc_req          (mc_req),
    .mc_addr         (mc_addr),
    .mc_done         (mc_done),
    .mc_inst         (mc_inst),
    .issue_stall     (issue_stall),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pred_pc    (inst_pred_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One lookup edge, expected to miss and raise a request for addr.
  task automatic expect_miss(input string tag, input logic [31:0] addr);
    tick();
    check_eq({tag, "_req"}, {31'h0, mc_req}, 32'h1);
    check_eq({tag, "_addr"}, mc_addr, addr);
  endtask

  // Memory controller returns a word; mc_req must still be high meanwhile.
  task automatic mem_done(input string tag, input logic [31:0] word);
    check_eq({tag, "_req_held"}, {31'h0, mc_req}, 32'h1);
    $display("mem %s: addr %h -> %h", tag, mc_addr, word);
    mc_done = 1'b1;
    mc_inst = word;
    tick();
    mc_done = 1'b0;
    mc_inst = 32'h0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc,
                           input logic [31:0] word, input logic [31:0] pred);
    check_eq({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    check_eq({tag, "_inst"}, inst, word);
    check_eq({tag, "_pc"}, inst_pc, pc);
    check_eq({tag, "_pred"}, inst_pred_pc, pred);
    check_eq({tag, "_req_low"}, {31'h0, mc_req}, 32'h0);
  endtask

  task automatic redirect(input string tag, input logic [31:0] target);
    $display("redirect %s: to %h", tag, target);
    jump_wrong_flag = 1'b1;
    jump_wrong_pc   = target;
    tick();
    jump_wrong_flag = 1'b0;
    jump_wrong_pc   = 32'h0;
    check_eq({tag, "_valid_clr"}, {31'h0, inst_valid}, 32'h0);
    check_eq({tag, "_req_clr"}, {31'h0, mc_req}, 32'h0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_req", {31'h0, mc_req}, 32'h0);
    check_eq("rst_addr", mc_addr, 32'h0);
    check_eq("rst_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_pc", inst_pc, 32'h0);
    check_eq("rst_pred", inst_pred_pc, 32'h0);
    rst = 1'b0;

    // Cold start: request for RESET_PC, held stable while waiting
    expect_miss("cold", 32'h0);
    tick();
    tick();
    check_eq("cold_hold_req", {31'h0, mc_req}, 32'h1);
    check_eq("cold_hold_addr", mc_addr, 32'h0);
    mem_done("cold", 32'h00000013);
    check_out("cold", 32'h0, 32'h00000013, 32'h4);
    expect_miss("seq4", 32'h4);

    // Stall: output held for 5 cycles with no new request
    issue_stall = 1'b1;
    mem_done("stall", 32'h00000013);
    check_out("stall", 32'h4, 32'h00000013, 32'h8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_pc", inst_pc, 32'h4);
      check_eq("stall_valid", {31'h0, inst_valid}, 32'h1);
      check_eq("stall_req", {31'h0, mc_req}, 32'h0);
    end
    issue_stall = 1'b0;
    expect_miss("unstall", 32'h8);
    check_eq("unstall_valid", {31'h0, inst_valid}, 32'h0);

    // rdy low: a completion pulse is ignored and everything holds
    rdy     = 1'b0;
    mc_done = 1'b1;
    mc_inst = 32'hDEADBEEF;
    tick();
    mc_done = 1'b0;
    mc_inst = 32'h0;
    rdy     = 1'b1;
    check_eq("rdy0_req", {31'h0, mc_req}, 32'h1);
    check_eq("rdy0_addr", mc_addr, 32'h8);
    check_eq("rdy0_valid", {31'h0, inst_valid}, 32'h0);

    // Redirect racing mc_done: word discarded, low PC bits forced to 0
    mc_done = 1'b1;
    mc_inst = 32'h12345013;
    redirect("race", 32'h00000103);
    mc_done = 1'b0;
    mc_inst = 32'h0;
    expect_miss("race_next", 32'h100);
    mem_done("r100", 32'h00000013);
    check_out("r100", 32'h100, 32'h00000013, 32'h104);

    // JAL positive offset
    redirect("jalp", 32'h10);
    expect_miss("jalp", 32'h10);
    mem_done("jalp", 32'h0080006F);
    check_out("jalp", 32'h10, 32'h0080006F, 32'h18);
    expect_miss("jalp_tgt", 32'h18);

    // JAL negative offset (-8)
    redirect("jaln", 32'h40);
    expect_miss("jaln", 32'h40);
    mem_done("jaln", 32'hFF9FF06F);
    check_out("jaln", 32'h40, 32'hFF9FF06F, 32'h38);
    expect_miss("jaln_tgt", 32'h38);

    // Refetch of 0 after it was filled
    redirect("hit0", 32'h0);
`ifdef ICACHE_EN
    tick();
    check_out("hit0", 32'h0, 32'h00000013, 32'h4);
    tick();
    check_out("hit4", 32'h4, 32'h00000013, 32'h8);
`else
    expect_miss("hit0", 32'h0);
    mem_done("hit0", 32'h00000013);
    check_out("hit0", 32'h0, 32'h00000013, 32'h4);
`endif

    // Alias: 0x400 maps to index 0 and evicts 0x0
    redirect("alias", 32'h400);
    expect_miss("alias", 32'h400);
    mem_done("alias", 32'h00100093);
    check_out("alias", 32'h400, 32'h00100093, 32'h404);
    redirect("evict", 32'h0);
    expect_miss("evict", 32'h0);
    mem_done("evict", 32'h00000013);
    check_out("evict", 32'h0, 32'h00000013, 32'h4);

    // The discarded race word at 0x8 must not have been filled
    redirect("nofill", 32'h8);
    expect_miss("nofill", 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
